// File: rtl/mu_state_sequencer.sv
// -----------------------------------------------------------------------------
// mu_state_sequencer
//
// Moves the six per-layer mu_dt gains (theta, L6, L5b, L5a, L4, L2/3) between
// the global oscillator states (NORMAL, ANESTHESIA, PSYCHEDELIC, FLOW,
// MEDITATION). Gains slew one LSB per ramp step toward the new targets, which
// keeps the oscillator banks free of step discontinuities. Every settled
// transition is followed by a minimum dwell before a new request is taken.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   clk_en              update-rate enable; qualifies all timers and steps
//   req_valid/req_ready state-change handshake (ready only while idle)
//   req_state           requested state code, 0..4 valid, 5..7 map to NORMAL
//   busy                FSM is ramping or dwelling
//   cur_state           last fully settled state
//   settled             one-clk pulse after a transition completes
//   err_invalid         one-clk pulse after an out-of-range code is accepted
//   mu_dt_*             registered signed gains, one per oscillator layer
// -----------------------------------------------------------------------------
module mu_state_sequencer #(
  parameter int WIDTH     = 18,
  parameter int RAMP_DIV  = 16,
  parameter int MIN_DWELL = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    req_valid,
  input  logic [2:0]              req_state,
  output logic                    req_ready,
  output logic                    busy,
  output logic [2:0]              cur_state,
  output logic                    settled,
  output logic                    err_invalid,
  output logic signed [WIDTH-1:0] mu_dt_theta,
  output logic signed [WIDTH-1:0] mu_dt_l6,
  output logic signed [WIDTH-1:0] mu_dt_l5b,
  output logic signed [WIDTH-1:0] mu_dt_l5a,
  output logic signed [WIDTH-1:0] mu_dt_l4,
  output logic signed [WIDTH-1:0] mu_dt_l23
);

  localparam int NLAYER  = 6;
  localparam int DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DWELL_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(RAMP_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'((MIN_DWELL > 0) ? (MIN_DWELL - 1) : 0);

  localparam logic signed [WIDTH-1:0] GAIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [WIDTH-1:0] GAIN_FULL = {{(WIDTH-3){1'b0}}, 3'd4};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  // Target level table, packed {l23, l4, l5a, l5b, l6, theta}, 3 bits each,
  // so layer i occupies bits [3*i +: 3]. Unknown codes fall back to NORMAL.
  function automatic logic [17:0] level_table(input logic [2:0] code);
    logic [17:0] v;
    case (code)
      3'd0:    v = {3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4}; // NORMAL
      3'd1:    v = {3'd1, 3'd1, 3'd2, 3'd2, 3'd6, 3'd2}; // ANESTHESIA
      3'd2:    v = {3'd6, 3'd6, 3'd4, 3'd4, 3'd2, 3'd4}; // PSYCHEDELIC
      3'd3:    v = {3'd4, 3'd4, 3'd6, 3'd6, 3'd2, 3'd4}; // FLOW
      3'd4:    v = {3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4}; // MEDITATION
      default: v = {3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    endcase
    return v;
  endfunction

  // Zero-extend a 3-bit level into a signed gain word.
  function automatic logic signed [WIDTH-1:0] level_to_gain(input logic [2:0] lvl);
    return $signed({{(WIDTH-3){1'b0}}, lvl});
  endfunction

  // Out-of-range codes are served as NORMAL.
  function automatic logic [2:0] resolve_code(input logic [2:0] code);
    return (code > 3'd4) ? 3'd0 : code;
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [2:0]         tgt_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic [DWELL_W-1:0] dwell_cnt_r;

  logic signed [WIDTH-1:0] gain_r      [NLAYER];
  logic signed [WIDTH-1:0] tgt_gain_s  [NLAYER];
  logic signed [WIDTH-1:0] req_gain_s  [NLAYER];
  logic signed [WIDTH-1:0] next_gain_s [NLAYER];

  logic [2:0]  req_code_s;
  logic [17:0] tgt_lvl_s;
  logic [17:0] req_lvl_s;
  logic        accept_s;
  logic        req_match_s;
  logic        step_edge_s;
  logic        step_done_s;
  logic        dwell_done_s;

  // Decode the latched and the requested targets into gain words.
  always_comb begin
    req_code_s = resolve_code(req_state);
    tgt_lvl_s  = level_table(tgt_r);
    req_lvl_s  = level_table(req_code_s);
    for (int i = 0; i < NLAYER; i++) begin
      tgt_gain_s[i] = level_to_gain(tgt_lvl_s[3*i +: 3]);
      req_gain_s[i] = level_to_gain(req_lvl_s[3*i +: 3]);
    end
  end

  // Handshake, one-LSB step toward target, and completion detection.
  always_comb begin
    accept_s    = req_valid && (state_r == ST_IDLE);
    step_edge_s = (state_r == ST_RAMP) && clk_en && (div_cnt_r == DIV_LAST);
    req_match_s = 1'b1;
    step_done_s = 1'b1;
    for (int i = 0; i < NLAYER; i++) begin
      req_match_s = req_match_s && (req_gain_s[i] == gain_r[i]);
      if (gain_r[i] < tgt_gain_s[i]) begin
        next_gain_s[i] = gain_r[i] + GAIN_ONE;
      end else if (gain_r[i] > tgt_gain_s[i]) begin
        next_gain_s[i] = gain_r[i] - GAIN_ONE;
      end else begin
        next_gain_s[i] = gain_r[i];
      end
      step_done_s = step_done_s && (next_gain_s[i] == tgt_gain_s[i]);
    end
    // A zero dwell leaves DWELL on the very next clock, enable or not.
    if (MIN_DWELL == 0) begin
      dwell_done_s = (state_r == ST_DWELL);
    end else begin
      dwell_done_s = (state_r == ST_DWELL) && clk_en && (dwell_cnt_r == DWELL_LAST);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // A request whose targets already match the gains settles in place.
        if (accept_s && !req_match_s) begin
          state_next_s = ST_RAMP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (step_edge_s && step_done_s) begin
          state_next_s = ST_DWELL;
        end else begin
          state_next_s = ST_RAMP;
        end
      end
      ST_DWELL: begin
        if (dwell_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DWELL;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_RAMP, ST_DWELL: begin
        req_ready = 1'b0;
        busy      = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  // Datapath: target latch, divider/dwell counters, gains, status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_r       <= 3'd0;
      div_cnt_r   <= '0;
      dwell_cnt_r <= '0;
      cur_state   <= 3'd0;
      settled     <= 1'b0;
      err_invalid <= 1'b0;
      for (int i = 0; i < NLAYER; i++) begin
        gain_r[i] <= GAIN_FULL;
      end
    end else begin
      settled     <= 1'b0;
      err_invalid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            tgt_r       <= req_code_s;
            div_cnt_r   <= '0;
            err_invalid <= (req_state > 3'd4);
            if (req_match_s) begin
              cur_state <= req_code_s;
              settled   <= 1'b1;
            end else begin
              cur_state <= cur_state;
            end
          end else begin
            tgt_r <= tgt_r;
          end
        end
        ST_RAMP: begin
          if (step_edge_s) begin
            div_cnt_r <= '0;
            for (int i = 0; i < NLAYER; i++) begin
              gain_r[i] <= next_gain_s[i];
            end
            if (step_done_s) begin
              cur_state   <= tgt_r;
              settled     <= 1'b1;
              dwell_cnt_r <= '0;
            end else begin
              cur_state <= cur_state;
            end
          end else if (clk_en) begin
            div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
          end else begin
            div_cnt_r <= div_cnt_r;
          end
        end
        ST_DWELL: begin
          if (clk_en) begin
            dwell_cnt_r <= dwell_cnt_r + {{(DWELL_W-1){1'b0}}, 1'b1};
          end else begin
            dwell_cnt_r <= dwell_cnt_r;
          end
        end
        default: begin
          div_cnt_r   <= '0;
          dwell_cnt_r <= '0;
        end
      endcase
    end
  end

  assign mu_dt_theta = gain_r[0];
  assign mu_dt_l6    = gain_r[1];
  assign mu_dt_l5b   = gain_r[2];
  assign mu_dt_l5a   = gain_r[3];
  assign mu_dt_l4    = gain_r[4];
  assign mu_dt_l23   = gain_r[5];

endmodule

// File: tb/tb_mu_state_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mu_state_sequencer
//
// Directed sequence of state changes with randomized clk_en patterns. The
// reference model works per transaction: each gain is start + sign * min(k, |d|)
// after k completed ramp steps, where k = clk_en ticks since acceptance divided
// by RAMP_DIV, followed by a dwell of MIN_DWELL ticks.
// -----------------------------------------------------------------------------
module tb_mu_state_sequencer;

  localparam int WIDTH     = 18;
  localparam int RAMP_DIV  = 16;
  localparam int MIN_DWELL = 64;
  localparam int BUDGET    = 4000;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clk_en;
  logic                    req_valid;
  logic [2:0]              req_state;
  logic                    req_ready;
  logic                    busy;
  logic [2:0]              cur_state;
  logic                    settled;
  logic                    err_invalid;
  logic signed [WIDTH-1:0] mu_dt_theta, mu_dt_l6, mu_dt_l5b, mu_dt_l5a, mu_dt_l4, mu_dt_l23;

  mu_state_sequencer #(.WIDTH(WIDTH), .RAMP_DIV(RAMP_DIV), .MIN_DWELL(MIN_DWELL)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_state(req_state), .req_ready(req_ready),
    .busy(busy), .cur_state(cur_state), .settled(settled), .err_invalid(err_invalid),
    .mu_dt_theta(mu_dt_theta), .mu_dt_l6(mu_dt_l6), .mu_dt_l5b(mu_dt_l5b),
    .mu_dt_l5a(mu_dt_l5a), .mu_dt_l4(mu_dt_l4), .mu_dt_l23(mu_dt_l23)
  );

  always #5 clk = ~clk;

  // Target table: theta, l6, l5b, l5a, l4, l23 per state code 0..4.
  int tbl [5][6] = '{
    '{4, 4, 4, 4, 4, 4},
    '{2, 6, 2, 2, 1, 1},
    '{4, 2, 4, 4, 6, 6},
    '{4, 2, 6, 6, 4, 4},
    '{4, 4, 2, 2, 2, 2}
  };

  int mg [6];
  int mcur;
  int checks = 0;
  int errors = 0;

  function automatic logic [127:0] pack_gains(input int g [6]);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[i*WIDTH +: WIDTH] = WIDTH'(g[i]);
    return v;
  endfunction

  function automatic logic [127:0] dut_gains();
    logic [127:0] v;
    v = '0;
    v[6*WIDTH-1:0] = {mu_dt_l23, mu_dt_l4, mu_dt_l5a, mu_dt_l5b, mu_dt_l6, mu_dt_theta};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ce(input int mode, input int cyc);
    case (mode)
      0:       clk_en = 1'b1;
      1:       clk_en = ((cyc % 4) == 0);
      default: clk_en = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One full request: accept, ramp, settle, dwell back to ready.
  // hold_code >= 0 keeps a further request asserted throughout.
  task automatic run_transition(input int code, input int mode, input int hold_code);
    int rc, d, di, ticks, dticks, cyc, k, steps_total;
    int s [6];
    int t [6];
    int e [6];
    logic en;
    bit done;
    rc = (code > 4) ? 0 : code;
    s = mg;
    t = tbl[rc];
    d = 0;
    for (int i = 0; i < 6; i++) begin
      di = (t[i] > s[i]) ? t[i] - s[i] : s[i] - t[i];
      if (di > d) d = di;
    end
    steps_total = d * RAMP_DIV;
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_state = 3'(code);
    drive_ce(mode, 0);
    @(posedge clk); #1;
    if (hold_code >= 0) begin
      req_valid = 1'b1;
      req_state = 3'(hold_code);
    end else begin
      req_valid = 1'b0;
    end
    chk("err_invalid_pulse", err_invalid, (code > 4));
    if (d == 0) begin
      chk("same_state_settled", settled, 1);
      chk("same_state_busy", busy, 0);
      chk("same_state_cur", cur_state, rc);
      mcur = rc;
      drive_ce(mode, 1);
      @(posedge clk); #1;
      chk("same_state_settled_off", settled, 0);
      chk("same_state_busy_after", busy, 0);
      return;
    end
    chk("busy_after_accept", busy, 1);
    chk("settled_after_accept", settled, 0);
    ticks = 0;
    cyc = 0;
    while (ticks < steps_total && cyc < BUDGET) begin
      drive_ce(mode, cyc + 1);
      en = clk_en;
      @(posedge clk); #1;
      cyc++;
      if (en) ticks++;
      k = ticks / RAMP_DIV;
      for (int i = 0; i < 6; i++) begin
        di = (t[i] > s[i]) ? t[i] - s[i] : s[i] - t[i];
        if (k >= di) e[i] = t[i];
        else e[i] = (t[i] > s[i]) ? s[i] + k : s[i] - k;
      end
      chk("ramp_gains", dut_gains(), pack_gains(e));
      chk("ramp_settled", settled, (ticks == steps_total));
      chk("ramp_cur_state", cur_state, (ticks == steps_total) ? rc : mcur);
      chk("ramp_ready", req_ready, 0);
      chk("ramp_err", err_invalid, 0);
    end
    chk("ramp_ticks", ticks, steps_total);
    mg = t;
    mcur = rc;
    dticks = 0;
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      drive_ce(mode, cyc);
      en = clk_en;
      @(posedge clk); #1;
      cyc++;
      if (en) dticks++;
      chk("dwell_ready", req_ready, (dticks >= MIN_DWELL));
      chk("dwell_busy", busy, (dticks < MIN_DWELL));
      chk("dwell_settled", settled, 0);
      chk("dwell_gains", dut_gains(), pack_gains(mg));
      if (dticks >= MIN_DWELL || req_ready === 1'b1) done = 1'b1;
      if (cyc >= BUDGET) begin
        chk("dwell_timeout", dticks, MIN_DWELL);
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int four [6];
    four = '{4, 4, 4, 4, 4, 4};
    rst = 1'b1;
    clk_en = 1'b0;
    req_valid = 1'b0;
    req_state = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gains", dut_gains(), pack_gains(four));
    chk("reset_cur_state", cur_state, 0);
    chk("reset_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_settled", settled, 0);
    chk("reset_err", err_invalid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    mg = four;
    mcur = 0;

    run_transition(1, 0, -1);   // NORMAL -> ANESTHESIA
    run_transition(6, 2, -1);   // invalid code from ANESTHESIA -> NORMAL
    run_transition(1, 0, -1);   // back to ANESTHESIA
    run_transition(2, 0, 3);    // -> PSYCHEDELIC with FLOW held while busy
    run_transition(3, 0, -1);   // held FLOW request accepted at first IDLE
    run_transition(4, 1, -1);   // -> MEDITATION at quarter-duty clk_en
    run_transition(4, 1, -1);   // same-state request
    repeat (6) run_transition(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), -1);
    run_transition(0, 0, -1);

    // Reset mid-RAMP must restore everything between clock edges.
    req_valid = 1'b1;
    req_state = 3'd1;
    clk_en = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midramp_reset_gains", dut_gains(), pack_gains(four));
    chk("midramp_reset_cur", cur_state, 0);
    chk("midramp_reset_ready", req_ready, 1);
    chk("midramp_reset_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mg = four;
    mcur = 0;
    run_transition(2, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
